mod_74x161_n: RTL and testbench

Parametrised synchronous up/down counter in the 74x160/161/163/191 family, generalised to WIDTH bits and an arbitrary modulus. It provides parallel load, the classic ENP/ENT cascade enables and a ripple-carry output, so wide counters are built by chaining instances. It sits alongside the gate-level 74xx models as the first generic sequential building block for timers, address generators and dividers.

---
 rtl/mod_74x161_n.sv | 66 ++++++
 tb/tb_mod_74x161_n.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_74x161_n.sv
// Generic WIDTH-bit, MODULUS-length synchronous up/down counter with parallel load,
// ENP/ENT cascade enables and ripple-carry out. MOD_74X161_N_SYNC_CLR_EN adds SCLR.
module mod_74x161_n #(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic             CLK,
   input  logic             CLR,
`ifdef MOD_74X161_N_SYNC_CLR_EN
   input  logic             SCLR,
`endif
   input  logic             LD,
   input  logic             ENP,
   input  logic             ENT,
   input  logic             UD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             RCO
);

   localparam logic [WIDTH-1:0] TOP_Q = WIDTH'(MODULUS - 64'd1);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             sclr;
   logic             out_of_range;
   logic             tc;

`ifdef MOD_74X161_N_SYNC_CLR_EN
   assign sclr = SCLR;
`else
   assign sclr = 1'b0;
`endif

   // States at or above MODULUS only arise from LD; never true when MODULUS == 2**WIDTH.
   assign out_of_range = (64'(q_q) >= MODULUS);

   // No handshake: every input is sampled on every rising CLK edge.
   always_comb begin
      q_d = q_q;
      if (sclr) begin
         q_d = '0;
      end else if (LD) begin
         q_d = D;
      end else if (ENP && ENT) begin
         if (!UD) begin
            q_d = (q_q >= TOP_Q) ? '0 : q_q + WIDTH'(1);
         end else begin
            q_d = ((q_q == '0) || out_of_range) ? TOP_Q : q_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign tc  = UD ? (q_q == '0) : (q_q == TOP_Q);
   assign RCO = ENT & tc;
   assign Q   = q_q;

endmodule

// File: tb/tb_mod_74x161_n.sv
// Bench for mod_74x161_n: a decade instance plus a two-stage hex cascade, checked against
// integer reference models with directed scenarios followed by randomized stimulus.
module tb_mod_74x161_n;

   localparam int DEC_MOD = 10;

   logic       clk = 1'b0;
   logic       clr, sclr, ld, enp, ent, ud;
   logic [3:0] d, q;
   logic       rco;

   logic       c_ld, c_enp, c_ent, c_ud;
   logic [3:0] c_d_lo, c_d_hi, c_q_lo, c_q_hi;
   logic       c_rco_lo, c_rco_hi;

   int n_tests = 0;
   int n_fail  = 0;
   int m_q     = 0;
   int m_cv    = 0;

   always #5 clk = ~clk;

   mod_74x161_n #(.WIDTH(4), .MODULUS(DEC_MOD)) u_dec (
      .CLK(clk), .CLR(clr),
`ifdef MOD_74X161_N_SYNC_CLR_EN
      .SCLR(sclr),
`endif
      .LD(ld), .ENP(enp), .ENT(ent), .UD(ud), .D(d), .Q(q), .RCO(rco)
   );

   mod_74x161_n #(.WIDTH(4), .MODULUS(16)) u_lo (
      .CLK(clk), .CLR(clr),
`ifdef MOD_74X161_N_SYNC_CLR_EN
      .SCLR(1'b0),
`endif
      .LD(c_ld), .ENP(c_enp), .ENT(c_ent), .UD(c_ud), .D(c_d_lo), .Q(c_q_lo), .RCO(c_rco_lo)
   );

   mod_74x161_n #(.WIDTH(4), .MODULUS(16)) u_hi (
      .CLK(clk), .CLR(clr),
`ifdef MOD_74X161_N_SYNC_CLR_EN
      .SCLR(1'b0),
`endif
      .LD(c_ld), .ENP(c_enp), .ENT(c_rco_lo), .UD(c_ud), .D(c_d_hi), .Q(c_q_hi), .RCO(c_rco_hi)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Decade reference: modular arithmetic, with loaded out-of-range values exiting on a count.
   function automatic int dec_next(int cur);
      if (sclr) return 0;
      if (ld) return int'(d);
      if (!(enp && ent)) return cur;
      if (!ud) return (cur >= DEC_MOD) ? 0 : (cur + 1) % DEC_MOD;
      return (cur >= DEC_MOD) ? DEC_MOD - 1 : (cur + DEC_MOD - 1) % DEC_MOD;
   endfunction

   function automatic logic dec_rco(int cur);
      return ent && (ud ? (cur == 0) : (cur == DEC_MOD - 1));
   endfunction

   // The cascade is one modulo-256 counter.
   function automatic int cas_next(int cur);
      if (c_ld) return int'(c_d_hi) * 16 + int'(c_d_lo);
      if (!(c_enp && c_ent)) return cur;
      return c_ud ? (cur + 255) % 256 : (cur + 1) % 256;
   endfunction

   task automatic check_rco();
      chk("dec_rco", 32'(rco), 32'(dec_rco(m_q)));
      chk("cas_rco", 32'(c_rco_hi),
          32'(c_ent && (c_ud ? (m_cv == 0) : (m_cv == 255))));
   endtask

   task automatic tick();
      if (clr) begin
         m_q  = 0;
         m_cv = 0;
      end else begin
         m_q  = dec_next(m_q);
         m_cv = cas_next(m_cv);
      end
      @(posedge clk);
      #1;
      chk("dec_q", 32'(q), 32'(m_q));
      chk("cas_q", 32'({c_q_hi, c_q_lo}), 32'(m_cv));
      check_rco();
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      #2;
      chk("async_clr_q", 32'(q), 32'd0);
      chk("async_clr_cas", 32'({c_q_hi, c_q_lo}), 32'd0);
      clr  = 1'b0;
      m_q  = 0;
      m_cv = 0;
   endtask

   initial begin
      clr = 1'b1; sclr = 1'b0; ld = 1'b0; enp = 1'b0; ent = 1'b1; ud = 1'b0; d = 4'd0;
      c_ld = 1'b0; c_enp = 1'b0; c_ent = 1'b0; c_ud = 1'b0; c_d_lo = 4'd0; c_d_hi = 4'd0;

      // Reset state and RCO behaviour while CLR is held
      #2;
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_rco_up", 32'(rco), 32'd0);
      ud = 1'b1;
      #1;
      chk("rst_rco_down", 32'(rco), 32'd1);
      clr = 1'b0;
      ud  = 1'b0;
      repeat (3) tick();
      chk("hold_q", 32'(q), 32'd0);

      // Decade up wrap
      enp = 1'b1;
      for (int i = 0; i < DEC_MOD; i++) begin
         tick();
         chk("up_wrap_q", 32'(q), 32'((i + 1) % DEC_MOD));
      end

      // Down count and out-of-range exits
      enp = 1'b0; ld = 1'b1; d = 4'd13;
      tick();
      chk("ld_oor", 32'(q), 32'd13);
      ld = 1'b0; enp = 1'b1; ud = 1'b1;
      tick();
      chk("down_oor", 32'(q), 32'd9);
      tick();
      chk("down_step", 32'(q), 32'd8);
      ld = 1'b1; d = 4'd0; tick();
      ld = 1'b0; tick();
      chk("down_from_0", 32'(q), 32'd9);
      ld = 1'b1; d = 4'd12; tick();
      ld = 1'b0; ud = 1'b0; tick();
      chk("up_oor", 32'(q), 32'd0);

      // Load wins over counting
      ld = 1'b1; d = 4'd5; tick();
      d = 4'd3; tick();
      chk("ld_prio_ent1", 32'(q), 32'd3);
      d = 4'd5; tick();
      ent = 1'b0; d = 4'd3; tick();
      chk("ld_prio_ent0", 32'(q), 32'd3);
      ld = 1'b0; ent = 1'b1;

      // Cascade carry from 0x0F to 0x10
      c_ld = 1'b1; c_d_lo = 4'hF; c_d_hi = 4'h0; tick();
      c_ld = 1'b0; c_enp = 1'b1; c_ent = 1'b1; c_ud = 1'b0;
      #1;
      chk("cas_rco_lo_at_f", 32'(c_rco_lo), 32'd1);
      tick();
      chk("cas_carry", 32'({c_q_hi, c_q_lo}), 32'h10);
      chk("cas_rco_lo_after", 32'(c_rco_lo), 32'd0);

      // Async clear between edges at Q=7
      enp = 1'b0; c_enp = 1'b0; ld = 1'b1; d = 4'd7; tick();
      ld = 1'b0;
      chk("pre_clr_q", 32'(q), 32'd7);
      clr_pulse();
      tick();

`ifdef MOD_74X161_N_SYNC_CLR_EN
      // Sync clear beats load
      ld = 1'b1; d = 4'd6; sclr = 1'b1; tick();
      chk("sclr_over_ld", 32'(q), 32'd0);
      sclr = 1'b0; ld = 1'b0;
`endif

      // Randomized stimulus against the models
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) clr_pulse();
         ld  = ($urandom_range(0, 7) == 0);
         d   = 4'($urandom_range(0, 15));
         enp = ($urandom_range(0, 3) != 0);
         ent = ($urandom_range(0, 3) != 0);
         ud  = 1'($urandom_range(0, 1));
`ifdef MOD_74X161_N_SYNC_CLR_EN
         sclr = ($urandom_range(0, 15) == 0);
`endif
         c_ld   = ($urandom_range(0, 15) == 0);
         c_d_lo = 4'($urandom_range(0, 15));
         c_d_hi = 4'($urandom_range(0, 15));
         c_enp  = ($urandom_range(0, 3) != 0);
         c_ent  = ($urandom_range(0, 3) != 0);
         c_ud   = 1'($urandom_range(0, 1));
         #1;
         check_rco();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
